branch_redirect_ctrl: RTL

Sequencing controller for branch resolution. It sits between the execute-stage branch unit and the fetch stage. It gives fetch a direction prediction from a table of 2-bit saturating counters. It also takes each resolved branch from execute, updates the table, and on a misprediction flushes the younger pipeline stages and hands the corrected PC to fetch over a valid/ready handshake.

---
 rtl/branch_redirect_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch direction predictor (2-bit saturating counters) plus the mispredict redirect/flush FSM.
// Optional counter table built only when BRANCH_BHT_EN is defined; otherwise fetch is predicted not-taken.
module branch_redirect_ctrl #(
    parameter  int BHT_ENTRIES = 64,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] fetch_pc_in,
    output logic        fetch_predicted_taken_out,
    input  logic        ex_valid_in,
    input  logic [63:0] ex_pc_in,
    input  logic        ex_taken_in,
    input  logic        ex_mispredicted_in,
    input  logic [63:0] ex_target_in,
    output logic        redirect_valid_out,
    output logic [63:0] redirect_pc_out,
    input  logic        redirect_ready_in,
    output logic        flush_out,
    output logic [31:0] mispredict_count_out,
    output logic [0:0]  state_dbg_out
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    logic [0:0]       r_state;
    logic [63:0]      r_redirect_pc;
    logic [31:0]      r_mispredict_count;
    logic             w_in_idle;
    logic             w_accept;
    logic             w_mispredict;
    logic             w_handshake;
    logic [63:0]      w_fallthrough_pc;
    logic [63:0]      w_redirect_pc;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;

    // Redirect handshake: fetch takes redirect_pc_out on a cycle where valid and ready are both 1;
    // valid stays high and the PC stays frozen until that cycle.
    assign w_in_idle        = (r_state == ST_IDLE);
    assign w_accept         = w_in_idle & ex_valid_in;
    assign w_mispredict     = w_accept & ex_mispredicted_in;
    assign w_handshake      = ~w_in_idle & redirect_ready_in;
    assign w_fallthrough_pc = ex_pc_in + 64'd4;
    assign w_redirect_pc    = ex_taken_in ? ex_target_in : w_fallthrough_pc;
    assign w_rd_idx         = fetch_pc_in[IDX_W+1:2];
    assign w_upd_idx        = ex_pc_in[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_redirect_pc      <= 64'd0;
            r_mispredict_count <= 32'd0;
        end else if (w_in_idle) begin
            if (w_mispredict) begin
                r_state            <= ST_REDIRECT;
                r_redirect_pc      <= {w_redirect_pc[63:2], 2'b00};
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end else if (w_handshake) begin
            r_state <= ST_IDLE;
        end
    end

    assign redirect_valid_out   = ~w_in_idle;
    assign flush_out            = ~w_in_idle;
    assign redirect_pc_out      = r_redirect_pc;
    assign mispredict_count_out = r_mispredict_count;
    assign state_dbg_out        = r_state;

`ifdef BRANCH_BHT_EN
    logic [1:0] r_bht [BHT_ENTRIES];
    logic [1:0] w_cur_ctr;
    logic [1:0] w_next_ctr;
    logic       w_unused_fetch_bits;

    assign w_cur_ctr = r_bht[w_upd_idx];

    always_comb begin
        w_next_ctr = w_cur_ctr;
        if (ex_taken_in) begin
            if (w_cur_ctr != 2'b11) w_next_ctr = w_cur_ctr + 2'd1;
        end else begin
            if (w_cur_ctr != 2'b00) w_next_ctr = w_cur_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (w_accept) begin
            r_bht[w_upd_idx] <= w_next_ctr;
        end
    end

    // Read sees the stored value only: a same-cycle update to this entry shows up next cycle.
    assign fetch_predicted_taken_out = r_bht[w_rd_idx][1];
    assign w_unused_fetch_bits       = ^{fetch_pc_in[63:IDX_W+2], fetch_pc_in[1:0]};
`else
    logic w_unused_bht;

    assign fetch_predicted_taken_out = 1'b0;
    assign w_unused_bht              = ^{fetch_pc_in, w_rd_idx, w_upd_idx};
`endif

endmodule
